spike_event_pipe_packer: RTL
============================

Name: spike_event_pipe_packer

Overview:
- Turns per-channel spike lines (Ia afferent, motoneuron, …) into time-stamped 16-bit event words in an on-chip FIFO.
- The FIFO is drained by the host over a block-throttled pipe-out endpoint.
- It replaces free-running per-cycle sampling of raw spike bits with a lossless, host-paced event stream; this is the readout end of the spike path.
- Sits between the neuron array outputs and the okBTPipeOut data/read/ready signals, all in one clock domain.

Parameters:
- NCH, 4, number of spike channels (1..4); channel index is 2 bits.
- DEPTH_LOG2, 10, log2 of FIFO depth in words (1024).
- BLOCK_WORDS, 256, minimum fill count at which pipe_ready asserts.
- TS_BITS, 12, timestamp width; fixed ≤12.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; low blocks edge capture and timestamp advance.
- tick  in  1  one-cycle strobe per simulation step; advances the timestamp.
- spike_in  in  NCH  per-channel spike level, synchronous to clk.
- pipe_read  in  1  pop request from the pipe-out endpoint.
- pipe_data  out  16  word presented to the pipe.
- pipe_ready  out  1  high when fill_count ≥ BLOCK_WORDS.
- fill_count  out  DEPTH_LOG2+1  words currently stored.
- drop_cnt  out  16  saturating count of events lost to full FIFO or pending overrun.
- ts_out  out  TS_BITS  current timestamp.

Behaviour:
- Reset (async assert, sync release): FIFO empty; ts, wrap count, pending flags, drop_cnt, pipe_data and pipe_ready all 0.
- Word format, by type field [15:14]:
  - 00: filler, always 16'h0000.
  - 01: spike; [13:12]=channel, [11:0]=timestamp at capture (zero-extended if TS_BITS<12).
  - 10: wrap marker; [13:0]=wrap count low 14 bits.
  - 11: overflow marker (optional feature only).
- Edge detect:
  - Previous spike_in is registered every cycle.
  - A rising edge on channel k in cycle N, with enable=1, sets pending[k] and latches ts into pend_ts[k] at the end of cycle N.
  - If tick coincides, the pre-increment ts is captured.
- Overrun: a rising edge while pending[k] is still set drops the new event and increments drop_cnt. The original pending entry is kept.
- Timestamp: on tick with enable=1, ts increments. Transition from all-ones to 0 increments the wrap count and sets wrap_pending.
- Arbiter, one FIFO write per cycle, priority in order:
  1. Lowest-index pending spike.
  2. wrap_pending.
  3. Overflow marker.
- A spike whose edge occurs in cycle N is written at the edge ending cycle N+1 if nothing else is pending; fill_count updates at that same edge.
- A pending flag clears when its word is written.
- FIFO full with no pop in the same cycle: the arbitrated word is dropped, its pending flag clears, and drop_cnt increments (saturates at 16'hFFFF). Full with a simultaneous pop: the write is accepted.
- Read:
  - pipe_read high in cycle R with FIFO non-empty: the head word is popped and driven on pipe_data from the edge ending R, so it is valid in cycle R+1.
  - Empty: no pop; pipe_data becomes 16'h0000.
  - Without pipe_read, pipe_data holds its value.
- pipe_ready is registered: it reflects fill_count ≥ BLOCK_WORDS one cycle after fill_count changes. The host may read a full block after seeing it.
- enable low:
  - No new captures; ts frozen.
  - Already-pending events still drain into the FIFO.
  - Reads continue.
- FIFO pointers wrap modulo 2^DEPTH_LOG2. fill_count ranges 0..2^DEPTH_LOG2.

Optional Feature:
- Macro: SPIKE_PACKER_OVF_MARKER_EN.
- Defined:
  - Each drop also increments a 14-bit saturating ovf_since counter and sets ovf_pending.
  - When the FIFO has space and no higher-priority word is pending, word {2'b11, ovf_since} is written, then ovf_since and ovf_pending clear.
  - The marker is never itself dropped; it waits for space.
- Undefined: no type-11 words are ever produced; drops are visible only through drop_cnt.

Test Plan:
- Reset, 5 ticks, spike_in[1] rising after the 5th tick, then pipe_read -> fill_count=1 two cycles after the edge; pipe_data=16'h5005 in the cycle after the read; fill_count=0.
- Rising edges on channels 0, 2 and 3 in the same cycle at ts=7 -> three words in order 16'h4007, 16'h6007, 16'h7007; drop_cnt=0.
- 4096 ticks with no spikes -> exactly one word 16'h8001; ts_out=0.
- Fill the FIFO with 1024 events, then one more edge with no read -> fill_count=1024, drop_cnt=1, pipe_ready=1. With the macro defined, after one read the next word written is 16'hC001.
- Empty FIFO, pipe_read pulsed -> pipe_data=16'h0000, fill_count stays 0. Write 255 events -> pipe_ready=0; the 256th -> pipe_ready=1 one cycle after fill_count=256.
- Assert reset_n=0 mid-stream with 10 words queued and pending flags set -> all outputs 0 immediately; after release, the first spike edge is stamped ts=0.

Source files
------------

// File: rtl/spike_event_pipe_packer.sv
// Spike-edge to time-stamped event packer with a host-paced FIFO drained by a block-throttled pipe-out.
// Optional overflow-marker words are enabled by defining SPIKE_PACKER_OVF_MARKER_EN.
module spike_event_pipe_packer #(
  parameter int NCH         = 4,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256,
  parameter int TS_BITS     = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [NCH-1:0]        spike_in,
  input  logic                  pipe_read,
  output logic [15:0]           pipe_data,
  output logic                  pipe_ready,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic [15:0]           drop_cnt,
  output logic [TS_BITS-1:0]    ts_out
);

  typedef enum logic [1:0] {
    WT_FILLER = 2'b00,
    WT_SPIKE  = 2'b01,
    WT_WRAP   = 2'b10,
    WT_OVF    = 2'b11
  } word_type_e;

  localparam logic [DEPTH_LOG2:0] FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] BLOCK_CNT = (DEPTH_LOG2+1)'(BLOCK_WORDS);

  logic [NCH-1:0]        spike_prev_q;
  logic [NCH-1:0]        pending_q, pending_d;
  logic [TS_BITS-1:0]    pend_ts_q [NCH];
  logic [TS_BITS-1:0]    pend_ts_d [NCH];
  logic [TS_BITS-1:0]    ts_q, ts_d;
  logic [13:0]           wrap_cnt_q, wrap_cnt_d;
  logic                  wrap_pend_q, wrap_pend_d;
  logic [15:0]           drop_q, drop_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [15:0]           pipe_data_q, pipe_data_d;
  logic                  ready_q;
  logic [15:0]           mem [1 << DEPTH_LOG2];

`ifdef SPIKE_PACKER_OVF_MARKER_EN
  logic [13:0]           ovf_since_q, ovf_since_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [14:0]           ovf_sum;
`endif

  logic [NCH-1:0]     capture, overrun, sel_mask;
  logic [1:0]         sel_ch;
  logic [TS_BITS-1:0] sel_ts;
  logic               sel_spike, sel_wrap, sel_ovf;
  logic [15:0]        cand_word;
  logic               do_pop, has_space, wr_en, wr_drop;
  logic [2:0]         n_drops;
  logic [16:0]        drop_sum;

  assign capture   = enable ? (spike_in & ~spike_prev_q) : '0;
  assign overrun   = capture & pending_q;
  assign do_pop    = pipe_read && (count_q != '0);
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign has_space = (count_q != FULL_CNT) || do_pop;

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    sel_mask  = pending_q & (~pending_q + NCH'(1));
    sel_ch    = '0;
    sel_ts    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_mask[k]) begin
        sel_ch = 2'(k);
        sel_ts = pend_ts_q[k];
      end
    end
    sel_spike = |pending_q;
    sel_wrap  = !sel_spike && wrap_pend_q;
    sel_ovf   = 1'b0;
    cand_word = {WT_FILLER, 14'h0000};
    if (sel_spike) begin
      cand_word = {WT_SPIKE, sel_ch, 12'(sel_ts)};
    end else if (sel_wrap) begin
      cand_word = {WT_WRAP, wrap_cnt_q};
    end
`ifdef SPIKE_PACKER_OVF_MARKER_EN
    else if (ovf_pend_q) begin
      sel_ovf   = 1'b1;
      cand_word = {WT_OVF, ovf_since_q};
    end
`endif
  end

  // Spike and wrap words are discarded when there is no room; the overflow marker just waits.
  assign wr_en   = (sel_spike || sel_wrap || sel_ovf) && has_space;
  assign wr_drop = (sel_spike || sel_wrap) && !has_space;

  always_comb begin
    pending_d   = pending_q;
    pend_ts_d   = pend_ts_q;
    ts_d        = ts_q;
    wrap_cnt_d  = wrap_cnt_q;
    wrap_pend_d = wrap_pend_q;
    n_drops     = {2'b00, wr_drop};

    if (sel_spike && (wr_en || wr_drop)) pending_d = pending_q & ~sel_mask;
    if (sel_wrap && (wr_en || wr_drop))  wrap_pend_d = 1'b0;

    for (int k = 0; k < NCH; k++) begin
      n_drops = n_drops + {2'b00, overrun[k]};
      if (capture[k] && !pending_q[k]) begin
        pending_d[k] = 1'b1;
        pend_ts_d[k] = ts_q;
      end
    end

    if (enable && tick) begin
      ts_d = ts_q + TS_BITS'(1);
      if (ts_q == '1) begin
        wrap_cnt_d  = wrap_cnt_q + 14'd1;
        wrap_pend_d = 1'b1;
      end
    end

    drop_sum = {1'b0, drop_q} + {14'b0, n_drops};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

`ifdef SPIKE_PACKER_OVF_MARKER_EN
    ovf_since_d = ovf_since_q;
    ovf_pend_d  = ovf_pend_q;
    if (sel_ovf && wr_en) begin
      ovf_since_d = '0;
      ovf_pend_d  = 1'b0;
    end
    ovf_sum = {1'b0, ovf_since_d} + {12'b0, n_drops};
    if (n_drops != '0) begin
      ovf_pend_d  = 1'b1;
      ovf_since_d = ovf_sum[14] ? 14'h3FFF : ovf_sum[13:0];
    end
`endif
  end

  always_comb begin
    wr_ptr_d    = wr_en  ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d     = count_q;
    if (wr_en && !do_pop) count_d = count_q + (DEPTH_LOG2+1)'(1);
    if (!wr_en && do_pop) count_d = count_q - (DEPTH_LOG2+1)'(1);
    pipe_data_d = pipe_data_q;
    if (do_pop)         pipe_data_d = mem[rd_ptr_q];
    else if (pipe_read) pipe_data_d = 16'h0000;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_prev_q <= '0;
      pending_q    <= '0;
      for (int k = 0; k < NCH; k++) pend_ts_q[k] <= '0;
      ts_q         <= '0;
      wrap_cnt_q   <= '0;
      wrap_pend_q  <= 1'b0;
      drop_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pipe_data_q  <= '0;
      ready_q      <= 1'b0;
`ifdef SPIKE_PACKER_OVF_MARKER_EN
      ovf_since_q  <= '0;
      ovf_pend_q   <= 1'b0;
`endif
    end else begin
      spike_prev_q <= spike_in;
      pending_q    <= pending_d;
      pend_ts_q    <= pend_ts_d;
      ts_q         <= ts_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pend_q  <= wrap_pend_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pipe_data_q  <= pipe_data_d;
      ready_q      <= (count_q >= BLOCK_CNT);
`ifdef SPIKE_PACKER_OVF_MARKER_EN
      ovf_since_q  <= ovf_since_d;
      ovf_pend_q   <= ovf_pend_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity, which keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= cand_word;
  end

  assign pipe_data  = pipe_data_q;
  assign pipe_ready = ready_q;
  assign fill_count = count_q;
  assign drop_cnt   = drop_q;
  assign ts_out     = ts_q;

endmodule
